alu_srcb_stage: RTL and testbench
=================================

Name: alu_srcb_stage

Overview:
- Parametrised successor to the ALU B-operand selector in the multicycle MIPS datapath.
- Generates every B-operand form from raw fields (reg2, 16-bit immediate, shamt) and selects one with a 3-bit control.
- Registers the selected operand into a 2-entry elastic buffer with valid/ready handshake, so the ALU B input is cleanly pipelined and can stall.

Parameters:
- WIDTH, 32, datapath/operand width (must be >= IMM_W+2).
- IMM_W, 16, raw immediate width.
- SHAMT_W, 5, shift-amount field width.
- INC_CONST, 4, constant driven for PC increment selection.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an operand request this cycle.
- in_ready  out  1  stage can accept a request.
- Reg2  in  WIDTH  read register 2 value.
- Imm  in  IMM_W  raw instruction immediate.
- Shamt  in  SHAMT_W  raw shift-amount field.
- ALUSrcB  in  3  operand select.
- out_valid  out  1  ValueB holds a valid operand.
- out_ready  in  1  ALU consumes ValueB this cycle.
- ValueB  out  WIDTH  B operand of the ALU operation.

Behaviour:
- Select decode, all zero/sign-extended to WIDTH:
  - 000 Reg2
  - 001 INC_CONST
  - 010 sign-ext Imm
  - 011 sign-ext Imm << 2, upper bits dropped
  - 100 zero-ext Imm
  - 101 Imm << (WIDTH-IMM_W) (LUI form, low bits 0)
  - 110 zero-ext Shamt
  - 111 reserved, yields 0
- Accept: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Storage: 2 entries, head and skid. ValueB always equals the head entry.
- FSM states and transitions:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE, with head = new operand.
  - ONE: out_valid=1, in_ready=1.
    - Accept and transfer together -> ONE; head replaced by new operand.
    - Accept only -> TWO; new operand goes to skid.
    - Transfer only -> EMPTY.
    - Neither -> ONE; head holds.
  - TWO: out_valid=1, in_ready=0.
    - Transfer -> ONE; head = skid.
    - No transfer -> TWO; head and skid hold.
    - in_valid is ignored while in_ready=0.
- Latency: operand presented on cycle N appears on ValueB at cycle N+1 when the buffer was EMPTY.
- Throughput: 1 operand/cycle when out_ready is held high.
- Ordering: strict FIFO order; no reordering, no drop, no duplicate.
- ValueB is stable while out_valid=1 and out_ready=0.
- in_ready is a registered function of state only, with no combinational path from out_ready.
- Reset: on a clk edge with reset=1, the state goes to EMPTY, out_valid=0, in_ready=1, ValueB=0, skid=0.
  - Reset mid-operation discards both entries; nothing is transferred in that cycle.
  - Reset has priority over simultaneous accept/transfer.
- Inputs are sampled only on accept; Reg2/Imm/Shamt/ALUSrcB are don't-care otherwise.

Optional Feature:
- Macro: ALUSRCB_ILLEGAL_SEL_EN.
- Defined:
  - Adds port illegal_sel (out, 1).
  - illegal_sel is a sticky flag, set on the cycle after an accept with ALUSrcB=111.
  - Cleared only by reset; reset value 0.
  - The operand is still enqueued as 0.
- Undefined:
  - The port is absent and 111 silently yields 0.
  - Datapath timing is identical in both builds.

Test Plan:
- Reset, then in_valid=1, ALUSrcB=000, Reg2=0x12345678, out_ready=1 -> next cycle out_valid=1, ValueB=0x12345678. Then in_valid=0 -> out_valid=0 the following cycle.
- Imm=0x8001 streamed with sel 010/011/100/101 and out_ready=1 -> ValueB sequence 0xFFFF8001, 0xFFFE0004, 0x00008001, 0x80010000 on consecutive cycles. Sel 001 -> 0x4. Sel 110 with Shamt=0x1F -> 0x1F.
- out_ready=0, push Reg2=0xA then 0xB -> in_ready=0 after the second accept and ValueB holds 0xA. Raise out_ready -> 0xA, then 0xB, in order. An in_valid offered with 0xC while full is not accepted.
- In ONE, accept and transfer in the same cycle for 8 cycles of Reg2=1..8 -> ValueB=1..8 consecutively; in_ready stays 1.
- Fill to TWO, assert reset for one cycle with in_valid=1 and out_ready=1 -> out_valid=0, in_ready=1, ValueB=0, and no stale operand appears afterwards.
- With ALUSRCB_ILLEGAL_SEL_EN: accept sel 111 -> ValueB=0 and illegal_sel=1, still 1 after further legal operands. Reset -> illegal_sel=0.

Source files
------------

// File: rtl/alu_srcb_stage.sv
// rtl/alu_srcb_stage.sv - ALU B-operand generator with 2-entry elastic output buffer
//
// Purpose:
//   Builds every B-operand form from the raw instruction fields and selects
//   one of them with ALUSrcB. The selected operand is registered into a
//   head/skid elastic buffer, so the ALU B input is pipelined and can stall.
//
// Optional feature macro: ALUSRCB_ILLEGAL_SEL_EN
//   When defined, the illegal_sel port is added. It is a sticky flag that
//   records any accepted request with ALUSrcB = 3'b111.
//
// Ports:
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high reset
//   in_valid     in   1        upstream has an operand request
//   in_ready     out  1        stage can accept a request
//   Reg2         in   WIDTH    read register 2 value
//   Imm          in   IMM_W    raw instruction immediate
//   Shamt        in   SHAMT_W  raw shift-amount field
//   ALUSrcB      in   3        operand select
//   out_valid    out  1        ValueB holds a valid operand
//   out_ready    in   1        ALU consumes ValueB this cycle
//   ValueB       out  WIDTH    B operand for the ALU
//   illegal_sel  out  1        sticky reserved-select flag (macro builds only)

module alu_srcb_stage #(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int SHAMT_W   = 5,
    parameter int INC_CONST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   Reg2,
    input  logic [IMM_W-1:0]   Imm,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic [2:0]         ALUSrcB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ValueB
`ifdef ALUSRCB_ILLEGAL_SEL_EN
    ,
    output logic               illegal_sel
`endif
);

    // Select encodings
    localparam logic [2:0] SEL_REG2   = 3'b000;
    localparam logic [2:0] SEL_INC    = 3'b001;
    localparam logic [2:0] SEL_SEXT   = 3'b010;
    localparam logic [2:0] SEL_SEXT_2 = 3'b011;
    localparam logic [2:0] SEL_ZEXT   = 3'b100;
    localparam logic [2:0] SEL_LUI    = 3'b101;
    localparam logic [2:0] SEL_SHAMT  = 3'b110;
    localparam logic [2:0] SEL_RSVD   = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] operand;

    logic             accept;
    logic             xfer;
    logic             head_load;
    logic             head_from_skid;
    logic             skid_load;

    // ------------------------------------------------------------------
    // Operand generation
    // ------------------------------------------------------------------
    assign imm_sext = {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm};
    assign imm_zext = {{(WIDTH-IMM_W){1'b0}}, Imm};

    always_comb begin
        operand = '0;
        case (ALUSrcB)
            SEL_REG2:   operand = Reg2;
            SEL_INC:    operand = WIDTH'(INC_CONST);
            SEL_SEXT:   operand = imm_sext;
            // Word-offset form: the two top bits of the extended value fall off.
            SEL_SEXT_2: operand = imm_sext << 2;
            SEL_ZEXT:   operand = imm_zext;
            // Immediate placed in the top IMM_W bits, low bits zero.
            SEL_LUI:    operand = {Imm, {(WIDTH-IMM_W){1'b0}}};
            SEL_SHAMT:  operand = {{(WIDTH-SHAMT_W){1'b0}}, Shamt};
            SEL_RSVD:   operand = '0;
            default:    operand = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Both flags decode the state register only, so in_ready has no
    // combinational dependency on out_ready.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_TWO);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign ValueB    = head;

    // ------------------------------------------------------------------
    // Elastic buffer FSM: next state and load controls
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_ONE;
                    head_load  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    // Head leaves and is replaced in the same cycle.
                    state_next = ST_ONE;
                    head_load  = 1'b1;
                end else if (accept) begin
                    state_next = ST_TWO;
                    skid_load  = 1'b1;
                end else if (xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so no accept can occur.
                if (xfer) begin
                    state_next     = ST_ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and storage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_next;
            if (head_load) begin
                head <= head_from_skid ? skid : operand;
            end
            if (skid_load) begin
                skid <= operand;
            end
        end
    end

`ifdef ALUSRCB_ILLEGAL_SEL_EN
    // Sticky: once a reserved select is accepted, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_sel <= 1'b0;
        end else if (accept && (ALUSrcB == SEL_RSVD)) begin
            illegal_sel <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_srcb_stage.sv
// tb/tb_alu_srcb_stage.sv - directed self-checking bench for alu_srcb_stage

module tb_alu_srcb_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Reg2;
    logic [15:0] Imm;
    logic [4:0]  Shamt;
    logic [2:0]  ALUSrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ValueB;
`ifdef ALUSRCB_ILLEGAL_SEL_EN
    logic        illegal_sel;
`endif

    int n_checks;
    int n_fail;

    alu_srcb_stage #(
        .WIDTH     (32),
        .IMM_W     (16),
        .SHAMT_W   (5),
        .INC_CONST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Reg2      (Reg2),
        .Imm       (Imm),
        .Shamt     (Shamt),
        .ALUSrcB   (ALUSrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ValueB    (ValueB)
`ifdef ALUSRCB_ILLEGAL_SEL_EN
        ,
        .illegal_sel (illegal_sel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (ValueB !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_valueb: got %h expected 00000000", ValueB);
        end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        ALUSrcB   = 3'b000;
        Reg2      = 32'h1234_5678;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || ValueB !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL latency_first: got v=%b %h expected v=1 12345678", out_valid, ValueB);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_decode();
        logic [2:0]  sels [8]  = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b001, 3'b110, 3'b000, 3'b111};
        logic [31:0] exps [8]  = '{32'hFFFF_8001, 32'hFFFE_0004, 32'h0000_8001, 32'h8001_0000,
                                   32'h0000_0004, 32'h0000_001F, 32'hCAFE_F00D, 32'h0000_0000};
        out_ready = 1'b1;
        Imm       = 16'h8001;
        Shamt     = 5'h1F;
        Reg2      = 32'hCAFE_F00D;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ALUSrcB = sels[i];
            step();
            n_checks++;
            if (out_valid !== 1'b1 || ValueB !== exps[i]) begin
                n_fail++;
                $display("FAIL decode_sel%b: got v=%b %h expected v=1 %h", sels[i], out_valid, ValueB, exps[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        ALUSrcB   = 3'b000;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Reg2      = 32'hA;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || ValueB !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_one: got v=%b r=%b %h expected v=1 r=1 0000000a", out_valid, in_ready, ValueB);
        end
        Reg2 = 32'hB;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || ValueB !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_two: got r=%b %h expected r=0 0000000a", in_ready, ValueB);
        end
        // Offered while full: must be ignored.
        Reg2 = 32'hC;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || ValueB !== 32'hA || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b r=%b %h expected v=1 r=0 0000000a", out_valid, in_ready, ValueB);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || ValueB !== 32'hB) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b r=%b %h expected v=1 r=1 0000000b", out_valid, in_ready, ValueB);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_c: got out_valid=%b value=%h expected out_valid=0", out_valid, ValueB);
        end
    endtask

    task automatic test_back_to_back();
        ALUSrcB   = 3'b000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            Reg2 = 32'(i);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || ValueB !== 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b r=%b %h expected v=1 r=1 %h", i, out_valid, in_ready, ValueB, 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        ALUSrcB   = 3'b000;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Reg2      = 32'h11;
        step();
        Reg2 = 32'h22;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_full: got in_ready=%b expected 0", in_ready);
        end
        reset     = 1'b1;
        Reg2      = 32'h33;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ValueB !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_reset: got v=%b r=%b %h expected v=0 r=1 00000000", out_valid, in_ready, ValueB);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_stale_%0d: got v=1 %h expected out_valid=0", i, ValueB);
            end
        end
    endtask

`ifdef ALUSRCB_ILLEGAL_SEL_EN
    task automatic test_illegal_sel();
        out_ready = 1'b1;
        n_checks++;
        if (illegal_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_initial: got %b expected 0", illegal_sel);
        end
        in_valid = 1'b1;
        ALUSrcB  = 3'b111;
        Reg2     = 32'h5555_5555;
        step();
        n_checks++;
        if (illegal_sel !== 1'b1 || ValueB !== 32'h0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_set: got flag=%b v=%b %h expected flag=1 v=1 00000000", illegal_sel, out_valid, ValueB);
        end
        ALUSrcB = 3'b000;
        step();
        step();
        n_checks++;
        if (illegal_sel !== 1'b1 || ValueB !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL ill_sticky: got flag=%b %h expected flag=1 55555555", illegal_sel, ValueB);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (illegal_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_reset: got %b expected 0", illegal_sel);
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Reg2      = '0;
        Imm       = '0;
        Shamt     = '0;
        ALUSrcB   = '0;
        test_reset();
        test_latency();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef ALUSRCB_ILLEGAL_SEL_EN
        test_illegal_sel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
